// File: rtl/btn_debounce.sv
// btn_debounce: push-button synchroniser and debouncer for the 25 MHz pixel
// clock domain. Each channel has a two-flop synchroniser, a stability counter
// and a four-state FSM. It drives a registered debounced level and one-cycle
// press and release pulses.
// Optional feature: define BTN_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press
// pulses while a button is held. When it is undefined, no repeat logic exists.
module btn_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic             CLK_25MHZ,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] BTN_RAW,
  output logic [WIDTH-1:0] BTN_LEVEL,
  output logic [WIDTH-1:0] BTN_PRESS,
  output logic [WIDTH-1:0] BTN_RELEASE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } state_t;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Two-flop synchroniser that brings the asynchronous pins into the clock domain.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= BTN_RAW;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             level_r;
    logic             level_s;
    logic             press_r;
    logic             press_s;
    logic             release_r;
    logic             release_s;
    logic             differ_s;
    logic             done_s;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_r;
    logic [RPT_W-1:0] rpt_s;
`endif

    // Next-state, stability counter and output pulse decode for one channel.
    always_comb begin
      state_s   = state_r;
      cnt_s     = '0;
      press_s   = 1'b0;
      release_s = 1'b0;
      differ_s  = (sync2_r[i] != level_r);
      done_s    = differ_s && (cnt_r == CNT_LAST);

      // A sample that matches the accepted level restarts the count.
      if (differ_s) begin
        if (done_s) begin
          cnt_s = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_s = '0;
      end

      case (state_r)
        STABLE_LO: begin
          if (sync2_r[i]) begin
            state_s = CHK_HI;
          end else begin
            state_s = STABLE_LO;
          end
        end
        CHK_HI: begin
          if (!sync2_r[i]) begin
            state_s = STABLE_LO;
          end else if (done_s) begin
            state_s = STABLE_HI;
            press_s = 1'b1;
          end else begin
            state_s = CHK_HI;
          end
        end
        STABLE_HI: begin
          if (!sync2_r[i]) begin
            state_s = CHK_LO;
          end else begin
            state_s = STABLE_HI;
          end
        end
        CHK_LO: begin
          if (sync2_r[i]) begin
            state_s = STABLE_HI;
          end else if (done_s) begin
            state_s   = STABLE_LO;
            release_s = 1'b1;
          end else begin
            state_s = CHK_LO;
          end
        end
        default: begin
          state_s = STABLE_LO;
        end
      endcase

      level_s = (state_s == STABLE_HI) || (state_s == CHK_LO);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      // The down-counter is loaded when STABLE_HI is entered. It fires a press
      // and reloads when it reaches zero. Outside STABLE_HI it stays cleared.
      rpt_s = '0;
      if (state_s == STABLE_HI) begin
        if (state_r != STABLE_HI) begin
          rpt_s = RPT_FIRST;
        end else if (rpt_r == '0) begin
          rpt_s   = RPT_NEXT;
          press_s = 1'b1;
        end else begin
          rpt_s = rpt_r - RPT_W'(1);
        end
      end else begin
        rpt_s = '0;
      end
`endif
    end

    // Channel state, counter and registered outputs.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
        state_r   <= STABLE_LO;
        cnt_r     <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rpt_r     <= '0;
`endif
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rpt_r     <= rpt_s;
`endif
      end
    end

    assign BTN_LEVEL[i]   = level_r;
    assign BTN_PRESS[i]   = press_r;
    assign BTN_RELEASE[i] = release_r;
  end

endmodule
